// File: rtl/misr_pkg.sv
// Shared types and helpers for the MISR signature analyzer: FSM state encoding,
// default feedback taps and the single-step compaction function.
package misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DEFAULT_POLY = 4'b1001;

  // One MISR step on a zero-extended word; callers truncate to their width.
  // Bit 0 takes the tap parity, every other bit takes its lower neighbour.
  function automatic logic [31:0] next_sig(input logic [31:0] sig,
                                           input logic [31:0] data,
                                           input logic [31:0] poly);
    return {sig[30:0], ^(sig & poly)} ^ data;
  endfunction

endpackage

// File: rtl/misr_core.sv
// WIDTH-bit multiple-input signature register with clear, compact,
// serial-shift and hold controls (priority in that order).
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_compact,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_scan_in,
  output logic [WIDTH-1:0] o_sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_compacted;

  assign w_compacted = WIDTH'(next_sig(32'(r_sig), 32'(i_data), 32'(POLY)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= '0;
    end else if (i_compact) begin
      r_sig <= w_compacted;
    end else if (i_shift) begin
      r_sig <= {r_sig[WIDTH-2:0], i_scan_in};
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/misr_signature_analyzer.sv
// BIST response compactor: folds N_PATTERNS valid words into a MISR, then
// compares the signature against golden and reports done/pass.
module misr_signature_analyzer
  import misr_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEFAULT_POLY),
  parameter int               N_PATTERNS = 15,
  localparam int              CNT_W      = $clog2(N_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] golden,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PATTERNS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             r_pass;

  logic             w_idle_like;
  logic             w_clear;
  logic             w_compact;
  logic             w_shift;
  logic [WIDTH-1:0] w_sig;

  // The signature is only scan-accessible while no run is in flight.
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_clear     = w_idle_like && start;
  assign w_compact   = (r_state == ST_RUN) && data_valid;
  assign w_shift     = w_idle_like && !start && scan_en;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_compact (w_compact),
    .i_shift   (w_shift),
    .i_data    (data_in),
    .i_scan_in (scan_in),
    .o_sig     (w_sig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (data_valid) begin
            r_count <= r_count + CNT_W'(1);
            if (r_count == LAST_IDX) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          r_pass  <= (w_sig == golden);
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (start) begin
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_count <= '0;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == ST_RUN) || (r_state == ST_CHECK);
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = w_sig;
  assign scan_out  = w_sig[WIDTH-1];

endmodule

// File: tb/tb_misr_signature_analyzer.sv
// Bench for misr_signature_analyzer: a 4-pattern instance and a default
// 15-pattern instance, checked every cycle against a word-folding model.
module tb_misr_signature_analyzer;

  localparam logic [3:0] POLY = 4'b1001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a[2], data_valid_a[2], scan_en_a[2], scan_in_a[2];
  logic       busy_a[2], done_a[2], pass_a[2], scan_out_a[2];
  logic [3:0] data_in_a[2], golden_a[2], sig_a[2];

  int n_assert = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  misr_signature_analyzer #(.WIDTH(4), .POLY(POLY), .N_PATTERNS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_a[0]), .data_in(data_in_a[0]),
    .data_valid(data_valid_a[0]), .golden(golden_a[0]), .scan_en(scan_en_a[0]),
    .scan_in(scan_in_a[0]), .scan_out(scan_out_a[0]), .signature(sig_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0])
  );

  misr_signature_analyzer u_dut15 (
    .clk(clk), .rst(rst), .start(start_a[1]), .data_in(data_in_a[1]),
    .data_valid(data_valid_a[1]), .golden(golden_a[1]), .scan_en(scan_en_a[1]),
    .scan_in(scan_in_a[1]), .scan_out(scan_out_a[1]), .signature(sig_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1])
  );

  // Signature after absorbing one word: doubling mod 16, plus the word,
  // plus the parity of the tapped bits added into bit 0.
  function automatic logic [3:0] fold(input logic [3:0] s, input logic [3:0] w);
    int v;
    v = (int'(s) * 2) % 16;
    v = v ^ int'(w) ^ ($countones(s & POLY) % 2);
    return v[3:0];
  endfunction

  function automatic int n_of(input int k);
    return (k == 0) ? 4 : 15;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Model: counts accepted words, schedules the golden check one edge later.
  logic [3:0] m_sig[2];
  int         m_words[2];
  logic       m_active[2], m_check_due[2], m_done[2], m_pass[2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_sig[k] <= 4'h0; m_words[k] <= 0; m_active[k] <= 1'b0;
        m_check_due[k] <= 1'b0; m_done[k] <= 1'b0; m_pass[k] <= 1'b0;
      end else if (m_check_due[k]) begin
        m_check_due[k] <= 1'b0;
        m_done[k]      <= 1'b1;
        m_pass[k]      <= (m_sig[k] == golden_a[k]);
      end else if (m_active[k]) begin
        if (data_valid_a[k]) begin
          m_sig[k]   <= fold(m_sig[k], data_in_a[k]);
          m_words[k] <= m_words[k] + 1;
          if (m_words[k] + 1 == n_of(k)) begin
            m_active[k]    <= 1'b0;
            m_check_due[k] <= 1'b1;
          end
        end
      end else if (start_a[k]) begin
        m_sig[k] <= 4'h0; m_words[k] <= 0; m_active[k] <= 1'b1;
        m_done[k] <= 1'b0; m_pass[k] <= 1'b0;
      end else if (scan_en_a[k]) begin
        m_sig[k] <= {m_sig[k][2:0], scan_in_a[k]};
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("sig%0d", k),  sig_a[k], m_sig[k]);
        chk($sformatf("busy%0d", k), 4'(busy_a[k]), 4'(m_active[k] | m_check_due[k]));
        chk($sformatf("done%0d", k), 4'(done_a[k]), 4'(m_done[k]));
        chk($sformatf("pass%0d", k), 4'(pass_a[k]), 4'(m_pass[k]));
        chk($sformatf("scan_out%0d", k), 4'(scan_out_a[k]), 4'(m_sig[k][3]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int k);
    start_a[k] = 1'b1;
    tick();
    start_a[k] = 1'b0;
  endtask

  task automatic feed(input int k, input logic [3:0] w, input int gap);
    data_in_a[k]    = w;
    data_valid_a[k] = 1'b1;
    tick();
    data_valid_a[k] = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("gap_busy", 4'(busy_a[k]), 4'h1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] lw[15];
  logic [3:0] ls;
  logic [3:0] lfsr_gold;
  logic [3:0] bad_w;

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_a[k] = 0; data_valid_a[k] = 0; scan_en_a[k] = 0; scan_in_a[k] = 0;
      data_in_a[k] = 4'h0; golden_a[k] = 4'h0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    tick();
    chk("reset_sig", sig_a[0], 4'h0);
    chk("reset_done", 4'(done_a[0]), 4'h0);
    cmp_en = 1'b1;

    // Words 1,0,0,0 back to back; golden matches.
    golden_a[0] = 4'hF;
    do_start(0);
    feed(0, 4'h1, 0); chk("t1_w1", sig_a[0], 4'h1);
    feed(0, 4'h0, 0); chk("t1_w2", sig_a[0], 4'h3);
    feed(0, 4'h0, 0); chk("t1_w3", sig_a[0], 4'h7);
    feed(0, 4'h0, 0); chk("t1_w4", sig_a[0], 4'hF);
    chk("t1_done_early", 4'(done_a[0]), 4'h0);
    tick();
    chk("t1_done", 4'(done_a[0]), 4'h1);
    chk("t1_pass", 4'(pass_a[0]), 4'h1);
    chk("t1_busy", 4'(busy_a[0]), 4'h0);

    // Same words with valid gaps of 1..3 cycles.
    do_start(0);
    chk("t2_done_clr", 4'(done_a[0]), 4'h0);
    feed(0, 4'h1, 1); feed(0, 4'h0, 2); feed(0, 4'h0, 3); feed(0, 4'h0, 0);
    tick();
    chk("t2_sig", sig_a[0], 4'hF);
    chk("t2_pass", 4'(pass_a[0]), 4'h1);

    // Wrong golden; result must hold with no start.
    golden_a[0] = 4'hE;
    do_start(0);
    feed(0, 4'h1, 0); feed(0, 4'h0, 0); feed(0, 4'h0, 0); feed(0, 4'h0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3_done", 4'(done_a[0]), 4'h1);
      chk("t3_pass", 4'(pass_a[0]), 4'h0);
      tick();
    end

    // Default instance fed by a 4-bit LFSR (x^4+x^3+1) seeded 0011.
    ls = 4'b0011;
    lfsr_gold = 4'h0;
    for (int i = 0; i < 15; i++) begin
      lw[i] = ls;
      lfsr_gold = fold(lfsr_gold, ls);
      ls = {ls[2:0], ls[3] ^ ls[2]};
    end
    golden_a[1] = lfsr_gold;
    for (int run = 0; run < 3; run++) begin
      do_start(1);
      for (int i = 0; i < 15; i++) begin
        bad_w = lw[i];
        if (run == 2 && i == 7) bad_w = lw[i] ^ 4'h1;
        feed(1, bad_w, 0);
      end
      chk("t4_done_early", 4'(done_a[1]), 4'h0);
      tick();
      chk("t4_done", 4'(done_a[1]), 4'h1);
      chk("t4_pass", 4'(pass_a[1]), (run == 2) ? 4'h0 : 4'h1);
    end

    // Asynchronous reset between edges in the middle of a run.
    golden_a[0] = 4'hF;
    do_start(0);
    feed(0, 4'h1, 0); feed(0, 4'h0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_sig", sig_a[0], 4'h0);
    chk("t5_busy", 4'(busy_a[0]), 4'h0);
    chk("t5_done", 4'(done_a[0]), 4'h0);
    #2 rst = 1'b0;
    tick();
    do_start(0);
    feed(0, 4'h1, 0); feed(0, 4'h0, 0); feed(0, 4'h0, 0); feed(0, 4'h0, 0);
    tick();
    chk("t5_resig", sig_a[0], 4'hF);
    chk("t5_pass", 4'(pass_a[0]), 4'h1);

    // Scan the signature out of DONE.
    scan_en_a[0] = 1'b1;
    scan_in_a[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_scan_out", 4'(scan_out_a[0]), 4'h1);
      tick();
    end
    scan_en_a[0] = 1'b0;
    chk("t6_sig", sig_a[0], 4'h0);
    chk("t6_pass_held", 4'(pass_a[0]), 4'h1);

    // Scan enable during a run must not disturb compaction.
    do_start(0);
    scan_en_a[0] = 1'b1;
    scan_in_a[0] = 1'b1;
    feed(0, 4'h1, 1); chk("t6_run_w1", sig_a[0], 4'h1);
    feed(0, 4'h0, 0); feed(0, 4'h0, 0); feed(0, 4'h0, 0);
    scan_en_a[0] = 1'b0;
    tick();
    chk("t6_run_sig", sig_a[0], 4'hF);
    chk("t6_run_pass", 4'(pass_a[0]), 4'h1);

    tick();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
